// File: rtl/mips_core_pkg.sv
// Shared core types for the branch-prediction path.
//   BranchOutcome      : resolved branch direction reported by EX (TAKEN = 1).
//   pht_sched_state_e  : states of the PHT access scheduler.
//   sat_update()       : 2-bit saturating counter step toward the observed outcome.
package mips_core_pkg;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    INIT   = 2'd1,
    RUN    = 2'd2,
    UPD_WB = 2'd3
  } pht_sched_state_e;

  // Already-saturated counters come back unchanged, so they are simply rewritten.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] result;
    if (taken) begin
      result = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end else begin
      result = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    end
    return result;
  endfunction

endpackage

// File: rtl/pht_update_fifo.sv
// Small synchronous FIFO holding queued PHT feedback entries ({idx, outcome}).
//   clk, rst : clock, asynchronous active-high reset (flushes the queue)
//   push/din : enqueue request and data; ignored while full
//   pop      : dequeue request; ignored while empty
//   full, empty, count : occupancy, all from registered state
//   head     : oldest entry, valid whenever !empty
module pht_update_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok;
  logic             pop_ok;
  logic [WIDTH-1:0] entry_q [DEPTH];

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] data_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_reg <= '0;
        end else if (push_ok && (wr_ptr_reg == PW'(gi))) begin
          data_reg <= din;
        end
      end

      assign entry_q[gi] = data_reg;
    end
  endgenerate

  assign head = entry_q[rd_ptr_reg];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/pht_access_scheduler.sv
// Arbiter for the single-port, sync-read gshare pattern history table.
//   clk, rst                      : clock, asynchronous active-high reset
//   req_valid/req_idx/req_ready   : decode lookup handshake
//   rsp_valid/rsp_counter/rsp_taken : lookup result, one cycle after accept
//   fb_valid/fb_idx/fb_outcome/fb_ready : EX feedback push into the update queue
//   init_done                     : table sweep to INIT_VAL finished
//   pht_en/pht_we/pht_addr/pht_wdata/pht_rdata : PHT memory port
module pht_access_scheduler
  import mips_core_pkg::*;
#(
  parameter int         IDX_BITS   = 8,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] INIT_VAL   = 2'b01
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [IDX_BITS-1:0] req_idx,
  output logic                req_ready,
  output logic                rsp_valid,
  output logic [1:0]          rsp_counter,
  output logic                rsp_taken,
  input  logic                fb_valid,
  input  logic [IDX_BITS-1:0] fb_idx,
  input  logic                fb_outcome,
  output logic                fb_ready,
  output logic                init_done,
  output logic                pht_en,
  output logic                pht_we,
  output logic [IDX_BITS-1:0] pht_addr,
  output logic [1:0]          pht_wdata,
  input  logic [1:0]          pht_rdata
);

  localparam int                  ENTRY_W  = IDX_BITS + 1;
  localparam int                  CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_BITS-1:0] LAST_IDX = '1;

  pht_sched_state_e    state_reg;
  logic [IDX_BITS-1:0] init_cnt_reg;
  logic                init_done_reg;
  logic                rsp_valid_reg;

  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [ENTRY_W-1:0]  fifo_head;
  logic                fifo_pop;
  logic                upd_rd;
  logic [IDX_BITS-1:0] head_idx;
  logic                head_taken;

  pht_update_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fb_valid),
    .din   ({fb_idx, fb_outcome}),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  assign head_idx   = fifo_head[ENTRY_W-1:1];
  assign head_taken = fifo_head[0];

  assign fb_ready    = ~fifo_full;
  assign init_done   = init_done_reg;
  assign rsp_valid   = rsp_valid_reg;
  // The PHT holds its read data, so gate it to keep the response bus quiet when idle.
  assign rsp_counter = rsp_valid_reg ? pht_rdata : 2'b00;
  assign rsp_taken   = rsp_counter[1];

  // Port arbitration. Lookups normally win; a full queue forces the head update
  // through so feedback cannot be starved indefinitely.
  always_comb begin
    pht_en    = 1'b0;
    pht_we    = 1'b0;
    pht_addr  = '0;
    pht_wdata = 2'b00;
    req_ready = 1'b0;
    upd_rd    = 1'b0;
    fifo_pop  = 1'b0;
    case (state_reg)
      INIT: begin
        pht_en    = 1'b1;
        pht_we    = 1'b1;
        pht_addr  = init_cnt_reg;
        pht_wdata = INIT_VAL;
      end
      RUN: begin
        if (fifo_full && (fifo_count != '0)) begin
          pht_en   = 1'b1;
          pht_addr = head_idx;
          upd_rd   = 1'b1;
        end else if (req_valid) begin
          req_ready = 1'b1;
          pht_en    = 1'b1;
          pht_addr  = req_idx;
        end else if (!fifo_empty) begin
          pht_en   = 1'b1;
          pht_addr = head_idx;
          upd_rd   = 1'b1;
        end
      end
      UPD_WB: begin
        // pht_rdata is the head counter read in the previous RUN cycle.
        pht_en    = 1'b1;
        pht_we    = 1'b1;
        pht_addr  = head_idx;
        pht_wdata = sat_update(pht_rdata, head_taken);
        fifo_pop  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= BOOT;
      init_cnt_reg  <= '0;
      init_done_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
    end else begin
      rsp_valid_reg <= req_ready;
      case (state_reg)
        BOOT: begin
          init_cnt_reg <= '0;
          state_reg    <= INIT;
        end
        INIT: begin
          init_cnt_reg <= init_cnt_reg + IDX_BITS'(1);
          if (init_cnt_reg == LAST_IDX) begin
            state_reg     <= RUN;
            init_done_reg <= 1'b1;
          end
        end
        RUN: begin
          if (upd_rd) state_reg <= UPD_WB;
        end
        UPD_WB: begin
          state_reg <= RUN;
        end
        default: state_reg <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pht_access_scheduler.sv
module tb_pht_access_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [7:0] req_idx = '0;
  logic       req_ready;
  logic       rsp_valid;
  logic [1:0] rsp_counter;
  logic       rsp_taken;
  logic       fb_valid = 1'b0;
  logic [7:0] fb_idx = '0;
  logic       fb_outcome = 1'b0;
  logic       fb_ready;
  logic       init_done;
  logic       pht_en;
  logic       pht_we;
  logic [7:0] pht_addr;
  logic [1:0] pht_wdata;
  logic [1:0] pht_rdata = 2'b00;

  pht_access_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_idx     (req_idx),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_counter (rsp_counter),
    .rsp_taken   (rsp_taken),
    .fb_valid    (fb_valid),
    .fb_idx      (fb_idx),
    .fb_outcome  (fb_outcome),
    .fb_ready    (fb_ready),
    .init_done   (init_done),
    .pht_en      (pht_en),
    .pht_we      (pht_we),
    .pht_addr    (pht_addr),
    .pht_wdata   (pht_wdata),
    .pht_rdata   (pht_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port sync-read PHT.
  logic [1:0] mem [256];
  always @(posedge clk) begin
    if (pht_en) begin
      if (pht_we) mem[pht_addr] <= pht_wdata;
      else        pht_rdata <= mem[pht_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected table contents plus the queue of accepted feedback.
  typedef struct {
    int idx;
    int taken;
  } fb_t;

  fb_t fbq[$];
  int  ref_tbl[256];
  bit  mon_en = 1'b0;
  bit  rsp_pend = 1'b0;
  int  rsp_exp = 0;

  function automatic int ref_next(input int ctr, input int taken);
    if (taken != 0) return (ctr < 3) ? ctr + 1 : 3;
    return (ctr > 0) ? ctr - 1 : 0;
  endfunction

  always @(negedge clk) begin
    bit  push_ok;
    fb_t h;
    if (mon_en) begin
      push_ok = (fbq.size() < 4);
      check("fb_ready", fb_ready, push_ok);
      if (rsp_pend) begin
        check("rsp_valid", rsp_valid, 1);
        check("rsp_counter", rsp_counter, rsp_exp);
        check("rsp_taken", rsp_taken, (rsp_exp >> 1) & 1);
      end else begin
        check("rsp_idle", rsp_valid, 0);
      end
      if (fbq.size() == 4) check("starve_guard", req_ready, 0);
      rsp_pend = 1'b0;
      if (req_ready) begin
        check("req_handshake", req_valid, 1);
        check("lookup_en", pht_en, 1);
        check("lookup_addr", pht_addr, req_idx);
        check("lookup_rd", pht_we, 0);
        rsp_pend = 1'b1;
        rsp_exp  = ref_tbl[req_idx];
      end
      if (pht_we) begin
        if (fbq.size() == 0) begin
          check("spurious_write", pht_we, 0);
        end else begin
          h = fbq.pop_front();
          check("upd_addr", pht_addr, h.idx);
          check("upd_data", pht_wdata, ref_next(ref_tbl[h.idx], h.taken));
          ref_tbl[h.idx] = ref_next(ref_tbl[h.idx], h.taken);
        end
      end
      if (fb_valid && push_ok) begin
        h.idx   = int'(fb_idx);
        h.taken = int'(fb_outcome);
        fbq.push_back(h);
      end
    end
  end

  task automatic step(input bit rv, input int ri, input bit fv, input int fi, input bit fo);
    @(posedge clk);
    #1;
    req_valid  = rv;
    req_idx    = 8'(ri);
    fb_valid   = fv;
    fb_idx     = 8'(fi);
    fb_outcome = fo;
  endtask

  // Asserts reset immediately, checks the quiet outputs, then follows the full init sweep.
  task automatic reset_and_init();
    mon_en    = 1'b0;
    rst       = 1'b1;
    req_valid = 1'b1;
    fb_valid  = 1'b0;
    #1;
    check("rst_pht_en", pht_en, 0);
    check("rst_pht_we", pht_we, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_init_done", init_done, 0);
    check("rst_fb_ready", fb_ready, 1);
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("boot_pht_en", pht_en, 0);
    check("boot_init_done", init_done, 0);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      check("init_we", {pht_en, pht_we}, 2'b11);
      check("init_addr", pht_addr, i);
      check("init_data", pht_wdata, 1);
      check("init_done_low", init_done, 0);
    end
    @(negedge clk);
    check("init_done_high", init_done, 1);
    check("post_init_idle", pht_en, 0);
    for (int i = 0; i < 256; i++) ref_tbl[i] = 1;
    fbq.delete();
    rsp_pend = 1'b0;
    mon_en   = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_and_init();

    // Lookup straight after init returns the sweep value.
    step(1, 'h12, 0, 0, 0);
    @(negedge clk);
    check("t2_req_ready", req_ready, 1);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    check("t2_rsp_valid", rsp_valid, 1);
    check("t2_rsp_counter", rsp_counter, 1);
    check("t2_rsp_taken", rsp_taken, 0);

    // Three TAKEN updates to idx 5 saturate at 3.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 5, 1);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0);
    step(1, 5, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    check("t3_rsp_counter", rsp_counter, 3);

    // Continuous lookups stall a single update until the queue fills.
    step(1, $urandom_range(0, 255), 1, 9, 0);
    for (int i = 0; i < 2; i++) begin
      step(1, $urandom_range(0, 255), 0, 0, 0);
      @(negedge clk);
      check("t4_stalled", pht_we, 0);
    end
    for (int i = 0; i < 3; i++) step(1, $urandom_range(0, 255), 1, 20 + i, 1);
    step(1, $urandom_range(0, 255), 0, 0, 0);
    @(negedge clk);
    check("t4_fb_ready_full", fb_ready, 0);
    check("t4_req_blocked", req_ready, 0);
    check("t4_upd_read", {pht_en, pht_we}, 2'b10);
    step(1, $urandom_range(0, 255), 0, 0, 0);
    @(negedge clk);
    check("t4_upd_write", pht_we, 1);
    step(1, $urandom_range(0, 255), 0, 0, 0);
    @(negedge clk);
    check("t4_lookup_resumes", req_ready, 1);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0);

    // Randomized mix: concurrent push/pop, pushes while full, lookups on hot indices.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 1), $urandom_range(0, 15),
           $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1));
    end
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0);
    @(negedge clk);
    check("drain_model_empty", fbq.size(), 0);
    check("drain_fb_ready", fb_ready, 1);

    // Reset in the middle of an update writeback.
    step(0, 0, 1, 7, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    check("t6_in_wb", pht_we, 1);
    #1;
    reset_and_init();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    step(1, 7, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    check("t6_idx7_reinit", rsp_counter, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
